masked_sbox_sched: RTL and testbench
====================================

Name: masked_sbox_sched

Overview:
- Round-robin scheduler that shares one pipelined masked AES S-box (5-stage DOM variant) among NREQ byte requesters, e.g. the round datapath and the key schedule.
- Accepts one shared byte per cycle, but only when fresh randomness is available.
- Tracks the requester ID of every in-flight byte through the S-box latency and returns each result, still shared, to the requester that issued it.
- Sits between the AES round controller/key expansion and the masked S-box instance plus its PRNG.

Parameters:
- SHARES, 2, number of Boolean shares per byte.
- NREQ, 2, number of requesters (2..8).
- SBOX_LAT, 4, register stages inside the attached masked S-box (input edge to output edge).
- IDW, 3, width of the requester ID field; must satisfy 2**IDW >= NREQ.

Ports:
- ClkxCI  in  1  clock
- RstxBI  in  1  reset, asynchronous, active-low
- ReqValidxSI  in  NREQ  request valid, one bit per requester
- ReqReadyxSO  out  NREQ  grant/accept, at most one bit set
- ReqDataxDI  in  NREQ*8*SHARES  shared input bytes; requester r occupies slice [r*8*SHARES +: 8*SHARES]
- RndValidxSI  in  1  PRNG has a fresh RandomZ/RandomB word for this cycle
- RndTakexSO  out  1  PRNG word consumed this cycle
- FlushxSI  in  1  synchronous kill of all in-flight work
- SboxInxDO  out  8*SHARES  registered S-box input
- SboxOutxDI  in  8*SHARES  S-box output
- RspValidxSO  out  NREQ  one-cycle result strobe, one-hot
- RspDataxDO  out  8*SHARES  registered shared result
- BusyxSO  out  1  work in flight

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Values after reset:
  - ReqReadyxSO, RspValidxSO, RndTakexSO and BusyxSO are 0.
  - SboxInxDO and RspDataxDO are 0.
  - All tag-pipe valid bits are 0.
  - The round-robin pointer is 0.
- Accept condition: a request is accepted in cycle t when RndValidxSI=1, FlushxSI=0 and at least one ReqValidxSI bit is 1.
- Grant selection: the granted requester g is the first requester with valid set, searching from the pointer upward with wrap-around.
- On accept:
  - ReqReadyxSO[g]=1 and RndTakexSO=1 in the same cycle; both are combinational.
  - The pointer becomes (g+1) mod NREQ.
- No accept: if RndValidxSI=0, all ready bits are 0 and RndTakexSO=0. This is a stall; no byte is ever issued without fresh masks.
- Valid/ready rules:
  - Ready may depend on valid.
  - A requester holds valid and data stable until it is accepted.
- Input register: at the edge ending cycle t, SboxInxDO loads the granted slice.
  - With no accept, SboxInxDO holds its previous value. It is never zeroed and never takes a mix of slices.
  - The input mux is one-hot AND-OR over whole share slices, so shares of different requesters are never combined.
- Tag pipe: SBOX_LAT+1 entries of {valid, id}, shifted every cycle.
  - Entry 0 loads {accept, g} at the same edge as SboxInxDO.
- Output register: when the last tag entry is valid, at the next edge:
  - RspDataxDO <= SboxOutxDI;
  - RspValidxSO <= onehot(id).
  - Otherwise RspValidxSO <= 0 and RspDataxDO holds its value.
- Latency: a request accepted in cycle t yields RspValidxSO in cycle t+SBOX_LAT+2; with defaults that is t+6.
- Throughput: one byte per cycle while randomness is available.
- No backpressure on responses: requesters must sink the strobe.
- Flush (FlushxSI=1 in cycle t):
  - Blocks accept in cycle t.
  - Clears all tag valid bits and RspValidxSO at the edge ending t.
  - Responses to work accepted before the flush are never issued.
  - The pointer and data registers are unaffected.
- Reset while work is in flight: all in-flight work is discarded. The S-box itself has no reset; its outputs are ignored until a fresh tag arrives.
- BusyxSO = OR of the tag valid bits OR any RspValidxSO bit (registered-state based).
- Simultaneous Flush and RndValidxSI: flush wins; RndTakexSO=0.
- Requests that are not valid are never granted, even if they are at the pointer.

Decomposition:
- Shared header aes_sched.vh, holding:
  - the function _sbox_lat(PIPELINED, EIGHT_STAGED), returning 4 for the 5-stage variant and 7 for the 8-stage variant;
  - the IDW helper function.
- One sub-module, rr_arbiter_onehot (parameter N), containing:
  - the valid vector input;
  - the enable input;
  - the one-hot grant output;
  - the pointer register.
- The tag pipe and data registers stay in the top module.

Test Plan:
- Single request: SHARES=2, requester 0 sends {0x53^0xA7, 0xA7} with RndValid=1 at t=0. Require Ready[0]=1 and RndTake=1 at t=0, RspValid=2'b01 at t=6, and the XOR of the result shares equal to 0xED.
- Contention: both requesters are valid continuously, requester 0 sends 0x00 and requester 1 sends 0x01, for 4 cycles. Require grants 0,1,0,1, responses at t=6..9 with RspValid 01,10,01,10, and unmasked results 0x63 and 0x7C respectively.
- Randomness stall: RndValid=0 for cycles 2–4 while requests pend. Require no Ready and no RndTake in those cycles, the SboxInxDO value unchanged, and the pointer unchanged.
- Flush: accept 3 bytes at t=0..2, then Flush=1 at t=3. Require no RspValid at t=6..8, and BusyxSO=0 from t=4.
- Async reset: drop RstxBI mid-stream at t=4 (not edge-aligned). Require all outputs to go to 0 immediately and no stale responses after release.
- Sparse valid with pointer wrap: NREQ=3, pointer=2, only requester 1 valid. Require a grant to requester 1, after which the pointer becomes 2.

Source files
------------

// File: rtl/masked_sbox_sched_pkg.sv
// Shared constants and elaboration helpers for the masked S-box scheduler.
package masked_sbox_sched_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    SBOX_DOM5 = 1'b0,
    SBOX_DOM8 = 1'b1
  } sboxVariant_e;

  // Register stages of the attached S-box between its input edge and output edge.
  function automatic int sboxLat(bit pipelined, bit eightStaged);
    if (!pipelined) return 1;
    return eightStaged ? 7 : 4;
  endfunction

  function automatic int idwFor(int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter_onehot #(
  parameter int N = 2
) (
  input  logic         ClkxCI,
  input  logic         RstxBI,
  input  logic [N-1:0] ValidxSI,
  input  logic         EnxSI,
  output logic [N-1:0] GrantxSO
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptrxDP;
  logic [PW-1:0] gIdx;
  logic          found;

  always_comb begin
    GrantxSO = '0;
    gIdx     = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = int'(ptrxDP) + i;
      if (idx >= N) idx = idx - N;
      if (!found && EnxSI && ValidxSI[idx]) begin
        found         = 1'b1;
        GrantxSO[idx] = 1'b1;
        gIdx          = PW'(idx);
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      ptrxDP <= '0;
    end else if (found) begin
      ptrxDP <= (gIdx == PW'(N - 1)) ? '0 : gIdx + PW'(1);
    end
  end

endmodule

// File: rtl/masked_sbox_sched.sv
// Shares one pipelined masked S-box among NREQ requesters; a tag pipe parallel
// to the S-box latency routes each still-shared result back to its issuer.
module masked_sbox_sched
  import masked_sbox_sched_pkg::*;
#(
  parameter int SHARES   = 2,
  parameter int NREQ     = 2,
  parameter int SBOX_LAT = sboxLat(1'b1, 1'b0),
  parameter int IDW      = 3
) (
  input  logic                          ClkxCI,
  input  logic                          RstxBI,
  input  logic [NREQ-1:0]               ReqValidxSI,
  output logic [NREQ-1:0]               ReqReadyxSO,
  input  logic [NREQ*BYTE_W*SHARES-1:0] ReqDataxDI,
  input  logic                          RndValidxSI,
  output logic                          RndTakexSO,
  input  logic                          FlushxSI,
  output logic [BYTE_W*SHARES-1:0]      SboxInxDO,
  input  logic [BYTE_W*SHARES-1:0]      SboxOutxDI,
  output logic [NREQ-1:0]               RspValidxSO,
  output logic [BYTE_W*SHARES-1:0]      RspDataxDO,
  output logic                          BusyxSO
);

  localparam int SW = BYTE_W * SHARES;

  logic [NREQ-1:0] grant;
  logic            accept;
  logic            arbEn;
  logic [SW-1:0]   muxIn;
  logic [IDW-1:0]  gId;
  logic [NREQ-1:0] rspOh;

  logic [SBOX_LAT:0] tagVld_p;
  logic [IDW-1:0]    tagId_p [SBOX_LAT+1];

  // Reset gating keeps the combinational grant silent while reset is asserted.
  assign arbEn = RndValidxSI & ~FlushxSI & RstxBI;

  rr_arbiter_onehot #(.N(NREQ)) uArb (
    .ClkxCI   (ClkxCI),
    .RstxBI   (RstxBI),
    .ValidxSI (ReqValidxSI),
    .EnxSI    (arbEn),
    .GrantxSO (grant)
  );

  assign ReqReadyxSO = grant;
  assign accept      = |grant;
  assign RndTakexSO  = accept;

  // Whole-slice AND-OR so shares from different requesters never mix.
  always_comb begin
    muxIn = '0;
    gId   = '0;
    for (int r = 0; r < NREQ; r++) begin
      muxIn = muxIn | ({SW{grant[r]}} & ReqDataxDI[r*SW +: SW]);
      if (grant[r]) gId = IDW'(r);
    end
  end

  // Stage p0: S-box input register and tag entry 0 load together.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      SboxInxDO <= '0;
      tagVld_p  <= '0;
    end else begin
      if (accept) SboxInxDO <= muxIn;
      if (FlushxSI) tagVld_p <= '0;
      else          tagVld_p <= {tagVld_p[SBOX_LAT-1:0], accept};
    end
  end

  always_ff @(posedge ClkxCI) begin
    tagId_p[0] <= gId;
    for (int k = 1; k <= SBOX_LAT; k++) tagId_p[k] <= tagId_p[k-1];
  end

  always_comb begin
    rspOh = '0;
    for (int r = 0; r < NREQ; r++) rspOh[r] = (tagId_p[SBOX_LAT] == IDW'(r));
  end

  // Output stage: capture the S-box result when the matching tag emerges.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      RspValidxSO <= '0;
      RspDataxDO  <= '0;
    end else if (FlushxSI) begin
      RspValidxSO <= '0;
    end else if (tagVld_p[SBOX_LAT]) begin
      RspValidxSO <= rspOh;
      RspDataxDO  <= SboxOutxDI;
    end else begin
      RspValidxSO <= '0;
    end
  end

  assign BusyxSO = (|tagVld_p) | (|RspValidxSO);

endmodule

// File: tb/tb_masked_sbox_sched.sv
// Directed bench for masked_sbox_sched with a behavioural 4-stage masked S-box.
module tb_masked_sbox_sched;

  localparam logic [7:0] M0 = 8'hA7;
  localparam logic [7:0] M1 = 8'h3C;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [31:0] reqData;
  logic        rndValid, rndTake, flush, busy;
  logic [15:0] sboxIn, sboxOut, rspData;
  logic [1:0]  rspValid;

  logic [2:0]  reqValid3, reqReady3, rspValid3;
  logic [47:0] reqData3;
  logic        rndValid3, rndTake3, busy3;
  logic [15:0] sboxIn3, rspData3;
  logic [15:0] sboxOut3;

  int nChecks = 0;
  int nErr    = 0;

  always #5 clk = ~clk;

  masked_sbox_sched #(.SHARES(2), .NREQ(2), .SBOX_LAT(4), .IDW(3)) dut (
    .ClkxCI(clk), .RstxBI(rstN), .ReqValidxSI(reqValid), .ReqReadyxSO(reqReady),
    .ReqDataxDI(reqData), .RndValidxSI(rndValid), .RndTakexSO(rndTake),
    .FlushxSI(flush), .SboxInxDO(sboxIn), .SboxOutxDI(sboxOut),
    .RspValidxSO(rspValid), .RspDataxDO(rspData), .BusyxSO(busy)
  );

  masked_sbox_sched #(.SHARES(2), .NREQ(3), .SBOX_LAT(4), .IDW(3)) dut3 (
    .ClkxCI(clk), .RstxBI(rstN), .ReqValidxSI(reqValid3), .ReqReadyxSO(reqReady3),
    .ReqDataxDI(reqData3), .RndValidxSI(rndValid3), .RndTakexSO(rndTake3),
    .FlushxSI(1'b0), .SboxInxDO(sboxIn3), .SboxOutxDI(sboxOut3),
    .RspValidxSO(rspValid3), .RspDataxDO(rspData3), .BusyxSO(busy3)
  );

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] aesSbox(logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    int e = 254;
    while (e > 0) begin
      if (e % 2 == 1) r = gmul(r, base);
      base = gmul(base, base);
      e = e / 2;
    end
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  // Masked S-box model: unmask, substitute, re-mask with a fresh mask.
  function automatic logic [15:0] maskedSbox(logic [15:0] in);
    logic [7:0] nm = in[15:8] ^ 8'h6B;
    return {nm, aesSbox(in[7:0] ^ in[15:8]) ^ nm};
  endfunction

  logic [15:0] sbPipe [4];
  always @(posedge clk) begin
    sbPipe[0] <= maskedSbox(sboxIn);
    sbPipe[1] <= sbPipe[0];
    sbPipe[2] <= sbPipe[1];
    sbPipe[3] <= sbPipe[2];
  end
  assign sboxOut  = sbPipe[3];
  assign sboxOut3 = 16'h0000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] v;
    logic       rnd, fl;
    logic [7:0] p0, p1;
    logic [1:0] rdy;
    logic       take;
    logic [1:0] rsp;
    logic [7:0] pl;
    logic       busy, ci;
    logic [7:0] ein;
  } vec_t;

  function automatic vec_t V(logic [1:0] v, logic rnd, logic fl, logic [7:0] p0, logic [7:0] p1,
                             logic [1:0] rdy, logic take, logic [1:0] rsp, logic [7:0] pl,
                             logic busy, logic ci, logic [7:0] ein);
    vec_t t;
    t.v = v; t.rnd = rnd; t.fl = fl; t.p0 = p0; t.p1 = p1; t.rdy = rdy; t.take = take;
    t.rsp = rsp; t.pl = pl; t.busy = busy; t.ci = ci; t.ein = ein;
    return t;
  endfunction

  function automatic vec_t IDLE(logic busy);
    return V(2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 8'h00, busy, 1'b0, 8'h00);
  endfunction

  task automatic drive2(logic [1:0] v, logic rnd, logic fl, logic [7:0] p0, logic [7:0] p1);
    reqValid = v;
    rndValid = rnd;
    flush    = fl;
    reqData  = {M1, p1 ^ M1, M0, p0 ^ M0};
  endtask

  vec_t vq[$];

  initial begin
    // Single request, then contention
    vq.push_back(V(2'b01,1,0,8'h53,8'h00, 2'b01,1, 2'b00,8'h00, 0, 0,8'h00));
    vq.push_back(V(2'b10,1,0,8'h00,8'h01, 2'b10,1, 2'b00,8'h00, 1, 1,8'h53));
    vq.push_back(V(2'b11,1,0,8'h00,8'h01, 2'b01,1, 2'b00,8'h00, 1, 1,8'h01));
    vq.push_back(V(2'b11,1,0,8'h00,8'h01, 2'b10,1, 2'b00,8'h00, 1, 1,8'h00));
    vq.push_back(V(2'b11,1,0,8'h00,8'h01, 2'b01,1, 2'b00,8'h00, 1, 1,8'h01));
    vq.push_back(V(2'b11,1,0,8'h00,8'h01, 2'b10,1, 2'b00,8'h00, 1, 1,8'h00));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b01,8'hED, 1, 1,8'h01));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b10,8'h7C, 1, 1,8'h01));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b01,8'h63, 1, 0,8'h00));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b10,8'h7C, 1, 0,8'h00));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b01,8'h63, 1, 0,8'h00));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b10,8'h7C, 1, 0,8'h00));
    vq.push_back(IDLE(0));
    // Randomness stall with requester 1 pending
    vq.push_back(V(2'b11,1,0,8'h00,8'h01, 2'b01,1, 2'b00,8'h00, 0, 0,8'h00));
    repeat (3) vq.push_back(V(2'b10,0,0,8'h00,8'h01, 2'b00,0, 2'b00,8'h00, 1, 1,8'h00));
    vq.push_back(V(2'b11,1,0,8'h00,8'h01, 2'b10,1, 2'b00,8'h00, 1, 1,8'h00));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b00,8'h00, 1, 1,8'h01));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b01,8'h63, 1, 0,8'h00));
    repeat (3) vq.push_back(IDLE(1));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b10,8'h7C, 1, 0,8'h00));
    vq.push_back(IDLE(0));
    // Flush of three in-flight bytes; flush beats fresh randomness
    vq.push_back(V(2'b01,1,0,8'h00,8'h00, 2'b01,1, 2'b00,8'h00, 0, 0,8'h00));
    vq.push_back(V(2'b10,1,0,8'h00,8'h01, 2'b10,1, 2'b00,8'h00, 1, 0,8'h00));
    vq.push_back(V(2'b01,1,0,8'h00,8'h00, 2'b01,1, 2'b00,8'h00, 1, 0,8'h00));
    vq.push_back(V(2'b11,1,1,8'h00,8'h01, 2'b00,0, 2'b00,8'h00, 1, 0,8'h00));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b00,8'h00, 0, 1,8'h00));
    repeat (5) vq.push_back(IDLE(0));
    // Pointer survives the flush
    vq.push_back(V(2'b11,1,0,8'h00,8'h01, 2'b10,1, 2'b00,8'h00, 0, 0,8'h00));
    repeat (5) vq.push_back(IDLE(1));
    vq.push_back(V(2'b00,1,0,8'h00,8'h00, 2'b00,0, 2'b10,8'h7C, 1, 0,8'h00));
    vq.push_back(IDLE(0));

    rstN = 1'b0;
    drive2(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    reqValid3 = 3'b000;
    rndValid3 = 1'b0;
    reqData3  = '0;

    repeat (2) @(negedge clk);
    drive2(2'b11, 1'b1, 1'b0, 8'h00, 8'h01);
    #1;
    chk("rst_ready", 32'(reqReady), 32'h0);
    chk("rst_take", 32'(rndTake), 32'h0);
    chk("rst_rspvalid", 32'(rspValid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sboxin", 32'(sboxIn), 32'h0);
    chk("rst_rspdata", 32'(rspData), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    drive2(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);

    foreach (vq[i]) begin
      @(negedge clk);
      drive2(vq[i].v, vq[i].rnd, vq[i].fl, vq[i].p0, vq[i].p1);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(reqReady), 32'(vq[i].rdy));
      chk($sformatf("v%0d_take", i), 32'(rndTake), 32'(vq[i].take));
      chk($sformatf("v%0d_rspvalid", i), 32'(rspValid), 32'(vq[i].rsp));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].busy));
      if (vq[i].rsp != 2'b00)
        chk($sformatf("v%0d_result", i), 32'(rspData[7:0] ^ rspData[15:8]), 32'(vq[i].pl));
      if (vq[i].ci)
        chk($sformatf("v%0d_sboxin", i), 32'(sboxIn[7:0] ^ sboxIn[15:8]), 32'(vq[i].ein));
    end

    // Async reset mid-cycle with three bytes in flight, pointer left at 1
    for (int a = 0; a < 3; a++) begin
      @(negedge clk);
      drive2(2'b11, 1'b1, 1'b0, 8'h00, 8'h01);
      #1;
      chk("ar_grant", 32'(reqReady), (a % 2 == 0) ? 32'h1 : 32'h2);
    end
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chk("ar_ready", 32'(reqReady), 32'h0);
    chk("ar_take", 32'(rndTake), 32'h0);
    chk("ar_rspvalid", 32'(rspValid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_sboxin", 32'(sboxIn), 32'h0);
    chk("ar_rspdata", 32'(rspData), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    drive2(2'b00, 1'b1, 1'b0, 8'h00, 8'h00);
    #1;
    chk("ar_stale_rsp", 32'(rspValid), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("ar_stale_rsp", 32'(rspValid), 32'h0);
      chk("ar_stale_busy", 32'(busy), 32'h0);
    end
    @(negedge clk);
    drive2(2'b11, 1'b1, 1'b0, 8'h00, 8'h01);
    #1;
    chk("ar_ptr_reset", 32'(reqReady), 32'h1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      drive2(2'b00, 1'b1, 1'b0, 8'h00, 8'h00);
      #1;
      chk("ar_fresh_rspvalid", 32'(rspValid), (j == 6) ? 32'h1 : 32'h0);
      if (j == 6) chk("ar_fresh_result", 32'(rspData[7:0] ^ rspData[15:8]), 32'h63);
    end

    // Three requesters: sparse valid with pointer wrap
    @(negedge clk);
    rndValid3 = 1'b1;
    reqValid3 = 3'b010;
    #1;
    chk("n3_first", 32'(reqReady3), 32'h2);
    chk("n3_take", 32'(rndTake3), 32'h1);
    @(negedge clk);
    reqValid3 = 3'b010;
    #1;
    chk("n3_wrap_grant", 32'(reqReady3), 32'h2);
    @(negedge clk);
    reqValid3 = 3'b111;
    #1;
    chk("n3_ptr_is_2", 32'(reqReady3), 32'h4);
    @(negedge clk);
    reqValid3 = 3'b111;
    #1;
    chk("n3_ptr_wraps_0", 32'(reqReady3), 32'h1);
    @(negedge clk);
    reqValid3 = 3'b000;
    rndValid3 = 1'b0;
    #1;
    chk("n3_idle", 32'(reqReady3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end

endmodule
